// File: rtl/sensor_spi_pkg.sv
// rtl/sensor_spi_pkg.sv - shared state encoding, frame constants and helpers for the sensor SPI register bus
package sensor_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        VERIFY
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // One rw bit followed by the address and data fields.
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/sensor_spi_shifter.sv
// rtl/sensor_spi_shifter.sv - SCLK divider and mode-1 frame shift engine
module sensor_spi_shifter #(
    parameter int FRAME_W = 16,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    input  logic               sdi_i,
    output logic               done,
    output logic               sclk_o,
    output logic               sdo_o,
    output logic [DATA_W-1:0]  rx_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_W);

    logic               active_q;
    logic [DIV_W-1:0]   div_q;
    logic [BIT_W-1:0]   bit_q;
    logic [FRAME_W-1:0] tx_q;
    logic               half_end;
    logic               last_bit;

    assign half_end = active_q && (div_q == DIV_W'(CLK_DIV - 1));
    assign last_bit = (bit_q == BIT_W'(FRAME_W - 1));
    // done is raised during the final clk of the last low half so the caller moves on at the frame boundary
    assign done     = half_end && !sclk_o && last_bit;

    // SCLK high half then low half per bit; drive sdo on the rise, capture sdi on the fall
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            sclk_o   <= 1'b0;
            sdo_o    <= 1'b0;
            rx_data  <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_o   <= 1'b1;
            sdo_o    <= frame[FRAME_W-1];
            tx_q     <= frame << 1;
        end else if (active_q) begin
            if (half_end) begin
                div_q <= '0;
                if (sclk_o) begin
                    sclk_o  <= 1'b0;
                    rx_data <= DATA_W'({rx_data, sdi_i});
                end else if (last_bit) begin
                    active_q <= 1'b0;
                    sdo_o    <= 1'b0;
                end else begin
                    bit_q  <= bit_q + 1'b1;
                    sclk_o <= 1'b1;
                    sdo_o  <= tx_q[FRAME_W-1];
                    tx_q   <= tx_q << 1;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_spi_regbus.sv
// rtl/sensor_spi_regbus.sv - register-access SPI master with CE timing; optional SENSOR_SPI_WRITE_VERIFY_EN readback
module sensor_spi_regbus #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_CS   = 2,
    parameter int CLK_DIV  = 50,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    output logic [NUM_CS-1:0]                              ce_o,
    output logic                                           sclk_o,
    output logic                                           sdo_o,
    input  logic                                           sdi_i,
    input  logic                                           req_valid_i,
    output logic                                           req_ready_o,
    input  logic                                           req_write_i,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] req_cs_i,
    input  logic [ADDR_W-1:0]                              req_addr_i,
    input  logic [DATA_W-1:0]                              req_wdata_i,
    output logic                                           rsp_valid_o,
    output logic [DATA_W-1:0]                              rsp_rdata_o,
    output logic                                           rsp_err_o,
    output logic                                           busy_o
);
    import sensor_spi_pkg::*;

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int MAX_T   = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                  : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int CNT_W   = $clog2(MAX_T + 1);
`ifdef SENSOR_SPI_WRITE_VERIFY_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, bad_q, verify_q;
    logic [CS_W-1:0]    cs_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               accept, bad_cs, sh_start, sh_done, hold_end, rb_now, rsp_fire;
    logic [FRAME_W-1:0] frame;
    logic [DATA_W-1:0]  sh_rdata;

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = ~req_ready_o;
    assign accept      = req_valid_i && req_ready_o;
    assign bad_cs      = ({1'b0, req_cs_i} >= (CS_W + 1)'(NUM_CS));
    // A clean write frame is followed by an automatic readback instead of a response
    assign rb_now      = RB_EN && write_q && !bad_q;
    assign rsp_fire    = hold_end && !rb_now;
    assign frame       = {write_q ? RW_WRITE : RW_READ, addr_q, write_q ? wdata_q : {DATA_W{1'b0}}};

    // Next-state and phase counter; GAP plus the following ready cycle make up the CE-low time
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_start = 1'b0;
        hold_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = bad_cs ? HOLD : SETUP;
                end
            end
            VERIFY: begin
                cnt_d   = '0;
                state_d = SETUP;
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    sh_start = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bad_q || cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    hold_end = 1'b1;
                    cnt_d    = '0;
                    if (CS_GAP > 1) state_d = GAP;
                    else            state_d = rb_now ? VERIFY : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 2)) state_d = verify_q ? VERIFY : IDLE;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and phase counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture, chip enables and response generation
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_o        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            write_q     <= 1'b0;
            bad_q       <= 1'b0;
            verify_q    <= 1'b0;
            cs_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_o <= rsp_fire;
            rsp_err_o   <= rsp_fire && (bad_q || (verify_q && sh_rdata != wdata_q));
            if (accept) begin
                write_q  <= req_write_i;
                bad_q    <= bad_cs;
                verify_q <= 1'b0;
                cs_q     <= req_cs_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                if (!bad_cs) ce_o <= NUM_CS'(1) << req_cs_i;
            end
            if (state_q == VERIFY) ce_o <= NUM_CS'(1) << cs_q;
            if (hold_end) begin
                ce_o <= '0;
                if (rb_now) begin
                    write_q  <= 1'b0;
                    verify_q <= 1'b1;
                end
            end
            if (rsp_fire) begin
                verify_q <= 1'b0;
                if (!write_q && !bad_q) rsp_rdata_o <= sh_rdata;
            end
        end
    end

    sensor_spi_shifter #(
        .FRAME_W (FRAME_W),
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (sh_start),
        .frame   (frame),
        .sdi_i   (sdi_i),
        .done    (sh_done),
        .sclk_o  (sclk_o),
        .sdo_o   (sdo_o),
        .rx_data (sh_rdata)
    );

endmodule
